// File: rtl/tempsens_pkg.sv
// Shared definitions for the temperature-sense chain (counter, window averager, UART mux).
package tempsens_pkg;

    localparam int TS_SAMPLE_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/ro_window_averager.sv
// Averages 2^LOG2_N ring-oscillator window counts into a held 16-bit mean.
// Optional min/max capture of each run is enabled by defining TEMPSENS_MINMAX_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start with en high; avg/avg_ready hold last result
// ST_ACCUM | summing sample_valid strobes until N have been taken
// ST_DONE  | single cycle: publish truncated mean, raise avg_ready
module ro_window_averager
    import tempsens_pkg::*;
#(
    parameter int W      = TS_SAMPLE_W,
    parameter int LOG2_N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         start,
    input  logic         sample_valid,
    input  logic [W-1:0] sample,
    output logic [W-1:0] avg,
    output logic         avg_ready,
    output logic         busy
`ifdef TEMPSENS_MINMAX_EN
    ,
    output logic [W-1:0] min_val,
    output logic [W-1:0] max_val
`endif
);

    localparam int AW = W + LOG2_N;
    localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_N) - 1);

    logic [1:0]    state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            avg       <= '0;
            avg_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && en) begin
                        acc       <= '0;
                        cnt       <= '0;
                        avg_ready <= 1'b0;
                        state     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    // Dropping en wins over a coincident final sample.
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (sample_valid) begin
                        acc <= acc + AW'(sample);
                        cnt <= cnt + CW'(1);
                        if (cnt == CNT_LAST) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    avg       <= W'(acc >> LOG2_N);
                    avg_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TEMPSENS_MINMAX_EN
    logic [W-1:0] min_trk;
    logic [W-1:0] max_trk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_trk <= '0;
            max_trk <= '0;
            min_val <= '0;
            max_val <= '0;
        end else begin
            if (state == ST_ACCUM && en && sample_valid) begin
                // First sample of a run seeds both trackers.
                if (cnt == '0 || sample < min_trk) min_trk <= sample;
                if (cnt == '0 || sample > max_trk) max_trk <= sample;
            end
            if (state == ST_DONE) begin
                min_val <= min_trk;
                max_val <= max_trk;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ro_window_averager.sv
// Scoreboard bench for ro_window_averager (LOG2_N=3 main instance, LOG2_N=0 side instance).
module tb_ro_window_averager;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample = '0;
    logic [15:0] avg;
    logic        avg_ready;
    logic        busy;

    logic        start0 = 1'b0;
    logic        sv0 = 1'b0;
    logic [15:0] sample0 = '0;
    logic [15:0] avg0;
    logic        ready0;
    logic        busy0;

`ifdef TEMPSENS_MINMAX_EN
    logic [15:0] min_val, max_val, min0, max0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] sb_q[$];
    logic        prev_ready = 1'b0;

    always #5 clk = ~clk;

    ro_window_averager #(.W(16), .LOG2_N(3)) u_dut (
        .clk(clk), .reset(reset), .en(en), .start(start),
        .sample_valid(sample_valid), .sample(sample),
        .avg(avg), .avg_ready(avg_ready), .busy(busy)
`ifdef TEMPSENS_MINMAX_EN
        , .min_val(min_val), .max_val(max_val)
`endif
    );

    ro_window_averager #(.W(16), .LOG2_N(0)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .start(start0),
        .sample_valid(sv0), .sample(sample0),
        .avg(avg0), .avg_ready(ready0), .busy(busy0)
`ifdef TEMPSENS_MINMAX_EN
        , .min_val(min0), .max_val(max0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result rising edge pops the oldest expected mean.
    always @(negedge clk) begin
        if (avg_ready && !prev_ready) begin
            if (sb_q.size() == 0) check("unexpected_ready", 32'd1, 32'd0);
            else                  check("sb_avg", {16'd0, avg}, {16'd0, sb_q.pop_front()});
        end
        prev_ready <= avg_ready;
    end

    // All tasks are entered and left at a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] v);
        sample       = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic run8(input logic [15:0] s[8], input string tag, output logic [15:0] exp);
        logic [18:0] sum;
        sum = '0;
        for (int i = 0; i < 8; i++) sum += 19'(s[i]);
        exp = sum[18:3];
        sb_q.push_back(exp);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        pulse_start();
        check({tag, "_busy_accum"}, {31'd0, busy}, 32'd1);
        check({tag, "_start_clr_rdy"}, {31'd0, avg_ready}, 32'd0);
        for (int i = 0; i < 8; i++) send(s[i]);
        check({tag, "_done_rdy"}, {31'd0, avg_ready}, 32'd0);
        check({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        check({tag, "_rdy"}, {31'd0, avg_ready}, 32'd1);
        check({tag, "_rdy_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run0(input logic [15:0] v, input string tag);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check({tag, "_busy"}, {31'd0, busy0}, 32'd1);
        sample0 = v;
        sv0     = 1'b1;
        @(negedge clk);
        sv0 = 1'b0;
        check({tag, "_done_rdy"}, {31'd0, ready0}, 32'd0);
        @(negedge clk);
        check({tag, "_rdy"}, {31'd0, ready0}, 32'd1);
        check({tag, "_avg"}, {16'd0, avg0}, {16'd0, v});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ref_s[8];
        logic [15:0] ff_s[8];
        logic [15:0] tr_s[8];
        logic [15:0] rn_s[8];
        logic [15:0] e;
        logic [15:0] last;

        ref_s = '{16'd100, 16'd102, 16'd98, 16'd101, 16'd99, 16'd100, 16'd103, 16'd97};
        ff_s  = '{default: 16'hFFFF};
        tr_s  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd1, 16'd1};

        repeat (2) @(negedge clk);
        check("rst_avg", {16'd0, avg}, 32'd0);
        check("rst_rdy", {31'd0, avg_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run8(ref_s, "ref", e);
        check("ref_avg", {16'd0, avg}, 32'd100);
`ifdef TEMPSENS_MINMAX_EN
        check("ref_min", {16'd0, min_val}, 32'd97);
        check("ref_max", {16'd0, max_val}, 32'd103);
`endif
        run8(ff_s, "ffff", e);
        check("ffff_avg", {16'd0, avg}, 32'hFFFF);
        run8(tr_s, "trunc", e);
        check("trunc_avg", {16'd0, avg}, 32'd1);

        // start with en low is ignored
        en = 1'b0;
        pulse_start();
        @(negedge clk);
        check("en0_start_busy", {31'd0, busy}, 32'd0);
        check("en0_start_rdy", {31'd0, avg_ready}, 32'd1);
        check("en0_start_avg", {16'd0, avg}, 32'd1);
        en = 1'b1;

        // en dropped after 5 samples aborts the run
        pulse_start();
        for (int i = 0; i < 5; i++) send(ref_s[i]);
        en = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rdy", {31'd0, avg_ready}, 32'd0);
        check("abort_avg", {16'd0, avg}, 32'd1);
`ifdef TEMPSENS_MINMAX_EN
        check("abort_min", {16'd0, min_val}, 32'd1);
        check("abort_max", {16'd0, max_val}, 32'd4);
`endif
        en = 1'b1;
        @(negedge clk);

        // stray sample_valid in IDLE, then a start pulse mid-ACCUM
        send(16'd5000);
        check("idle_sv_busy", {31'd0, busy}, 32'd0);
        sb_q.push_back(16'd100);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            if (i == 4) start = 1'b1;
            send(ref_s[i]);
            start = 1'b0;
        end
        check("midstart_done_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("midstart_rdy", {31'd0, avg_ready}, 32'd1);
        check("midstart_avg", {16'd0, avg}, 32'd100);

        // back-to-back random runs
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) rn_s[i] = 16'($urandom_range(0, 65535));
            run8(rn_s, "rand", e);
        end
        last = e;

        // en low wins over the final sample strobe
        pulse_start();
        for (int i = 0; i < 7; i++) send(ref_s[i]);
        en = 1'b0;
        send(ref_s[7]);
        en = 1'b1;
        check("prio_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("prio_rdy", {31'd0, avg_ready}, 32'd0);
        check("prio_avg", {16'd0, avg}, {16'd0, last});

        // async reset mid-ACCUM
        run8(ref_s, "pre_rst", e);
        pulse_start();
        for (int i = 0; i < 3; i++) send(ref_s[i]);
        #2 reset = 1'b0;
        #1;
        check("midrst_avg", {16'd0, avg}, 32'd0);
        check("midrst_rdy", {31'd0, avg_ready}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
`ifdef TEMPSENS_MINMAX_EN
        check("midrst_min", {16'd0, min_val}, 32'd0);
        check("midrst_max", {16'd0, max_val}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run8(ref_s, "post_rst", e);
        check("post_rst_avg", {16'd0, avg}, 32'd100);

        run0(16'd1234, "n1_a");
        run0(16'hABCD, "n1_b");

        repeat (2) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_window_averager.md
Name: ro_window_averager

Overview:
- Sits between the ring-oscillator pulse counter and the UART controller.
- Takes one count sample per measurement window from the counter.
- Accumulates 2^LOG2_N consecutive samples and emits their truncated mean as a 16-bit result for the UART byte mux.
- Started by the controller with a one-cycle pulse; it holds the result until the next start.

Parameters:
- W, 16, sample and result width in bits
- LOG2_N, 3, log2 of the number of samples averaged (N = 2^LOG2_N); legal range 0..8

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset; 0 = in reset
- en  input  1  measurement enable, shared with the oscillator and counter
- start  input  1  one-cycle pulse from the controller; begins a new averaging run
- sample_valid  input  1  one-cycle strobe; sample holds a completed window count
- sample  input  W  counter value for the completed window
- avg  output  W  mean of the last completed run
- avg_ready  output  1  level; high while avg holds a valid, unconsumed result
- busy  output  1  high in ACCUM and DONE

Behaviour:
- Reset (reset=0, asynchronous):
  - acc=0, cnt=0, avg=0, avg_ready=0, state=IDLE.
  - Reset asserted mid-run aborts the run immediately; no partial result is produced.
- Accumulator:
  - acc width is W+LOG2_N, so it cannot overflow.
  - cnt width is max(LOG2_N,1).
- State IDLE:
  - If start=1 and en=1: acc<=0, cnt<=0, avg_ready<=0, go to ACCUM.
  - If start=1 and en=0: ignored; avg and avg_ready are unchanged.
- State ACCUM:
  - Each cycle with sample_valid=1: acc<=acc+sample, cnt<=cnt+1.
  - When sample_valid=1 and cnt==N-1: go to DONE; the last sample is included in acc.
  - sample_valid in IDLE or DONE is ignored.
  - start while in ACCUM is ignored; the run is not restarted.
  - en=0 while in ACCUM: abort to IDLE next edge; avg is unchanged and avg_ready stays 0.
  - en=0 takes priority over a simultaneous final sample_valid.
- State DONE (exactly one cycle):
  - avg <= acc[W+LOG2_N-1:LOG2_N] (truncating divide), avg_ready<=1, go to IDLE.
- Latency:
  - avg_ready rises at the clock edge after the edge that accepted the Nth sample.
  - Total run = N sample strobes + 2 clocks.
- LOG2_N=0: a single sample completes the run and avg = sample.
- Back-to-back runs: start may arrive on the first IDLE cycle after DONE. That start clears avg_ready in the same edge.

Optional Feature:
- Macro: TEMPSENS_MINMAX_EN.
- When defined:
  - Adds outputs min_val[W-1:0] and max_val[W-1:0].
  - Both update in DONE together with avg, giving the extreme samples of the run.
  - Internal tracking registers load from the first sample of each run.
  - Reset value: min_val=0, max_val=0.
  - An aborted run does not update them.
- When undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package tempsens_pkg holds:
  - the state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2);
  - the constant TS_SAMPLE_W=16, used as the W default by the counter, this block and the UART mux.
- Single module; no sub-module is warranted. The FSM and accumulator are small and tightly coupled.

Test Plan:
- Reset mid-ACCUM (after 3 samples of 8): all outputs 0 immediately, state IDLE. A new start runs cleanly.
- LOG2_N=3, samples 100,102,98,101,99,100,103,97 (sum 800):
  - avg=100;
  - avg_ready rises one clock after the 8th sample_valid edge;
  - busy is high from start+1 through DONE.
- Truncation: eight samples of 0xFFFF, then eight samples summing to 15:
  - avg=0xFFFF (no overflow);
  - then avg=1 (15>>3).
- en dropped after 5 samples: return to IDLE, avg_ready=0, avg keeps the previous result. A start with en=0 is ignored.
- start pulsed during ACCUM and sample_valid pulsed in IDLE: both ignored; the sum and count match the clean-run reference.
- TEMPSENS_MINMAX_EN defined, samples 100,102,98,101,99,100,103,97: min_val=97, max_val=103, avg=100.
